// File: rtl/mult_scheduler_if.sv
// Request/result bus between the effect-path requesters and the shared
// Q1.15 multiplier scheduler. Requesters pack their operands side by side,
// with requester i at bits [i*WIDTH +: WIDTH].
interface mult_scheduler_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 3,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic [WIDTH-1:0]      res_data;

  // Requester side: offers operands, sees grants and tagged results.
  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, res_valid, res_id, res_data
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, res_valid, res_id, res_data
  );
endinterface

// File: rtl/mult_scheduler.sv
// Shared iterative shift-add Q1.(WIDTH-1) multiplier. Requests are
// arbitrated round-robin, the multiplier runs one bit per cycle on operand
// magnitudes, and the product is rounded half-up on magnitude, re-signed,
// saturated and returned tagged with the requester ID. A sticky overrun flag
// reports a sample tick arriving while work is still pending.
module mult_scheduler #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 3,
  parameter int IDW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic              overrun_clr,
  mult_scheduler_if.slave   bus,
  output logic              busy,
  output logic              overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;

  // Rounding bias of half an output LSB, and the two saturation limits
  // expressed on the (WIDTH+1)-bit rounded magnitude.
  localparam logic [PW-1:0]  ROUND_BIAS = PW'(1) << (WIDTH - 2);
  localparam logic [WIDTH:0] MAX_POS    = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH:0] MAX_NEG    = {2'b01, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    FINISH
  } state_t;

  state_t state, state_next;

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   cur_id;
  logic [NREQ-1:0]  grant_oh;
  logic             grant_found;
  logic             handshake;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             sign;
  logic [CW-1:0]    bit_cnt;
  logic             last_bit;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_next;
  logic [WIDTH:0]   rounded_mag;
  logic [WIDTH:0]   neg_mag;
  logic [WIDTH-1:0] sat_value;

  logic             res_valid_q;
  logic [IDW-1:0]   res_id_q;
  logic [WIDTH-1:0] res_data_q;

  // Magnitude of a two's complement operand; the most negative value maps
  // to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  // Round-robin search starting at rr_ptr; also muxes out the winner's operands.
  always_comb begin
    grant_oh    = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    in_a        = '0;
    in_b        = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_found && (j == (int'(rr_ptr) + k) % NREQ) && bus.req_valid[j]) begin
          grant_found = 1'b1;
          grant_oh[j] = 1'b1;
          grant_id    = IDW'(j);
          in_a        = bus.req_a[j*WIDTH +: WIDTH];
          in_b        = bus.req_b[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign handshake = grant_found && (state == IDLE);
  assign last_bit  = (bit_cnt == CW'(WIDTH - 1));

  // Shift-add step plus the round/re-sign/saturate of the running product.
  always_comb begin
    addend      = mag_b[bit_cnt] ? ({{WIDTH{1'b0}}, mag_a} << bit_cnt) : '0;
    acc_next    = acc + addend;
    rounded_mag = (WIDTH+1)'((acc_next + ROUND_BIAS) >> (WIDTH - 1));
    neg_mag     = (WIDTH+1)'(0) - rounded_mag;
    sat_value   = '0;
    if (!sign) begin
      sat_value = (rounded_mag > MAX_POS) ? {1'b0, {(WIDTH-1){1'b1}}}
                                          : rounded_mag[WIDTH-1:0];
    end else begin
      sat_value = (rounded_mag > MAX_NEG) ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : neg_mag[WIDTH-1:0];
    end
  end

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one grant, WIDTH multiply cycles, one result cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = MULT;
      MULT:    if (last_bit)  state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grants are only offered while idle; busy covers MULT and FINISH.
  always_comb begin
    bus.req_ready = (state == IDLE) ? grant_oh : '0;
    busy          = (state != IDLE);
  end

  // Datapath: capture at the handshake, accumulate in MULT, and register the
  // finished result on the last bit so it is presented during FINISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      cur_id      <= '0;
      mag_a       <= '0;
      mag_b       <= '0;
      sign        <= 1'b0;
      bit_cnt     <= '0;
      acc         <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            mag_a   <= abs_mag(in_a);
            mag_b   <= abs_mag(in_b);
            sign    <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
            cur_id  <= grant_id;
            acc     <= '0;
            bit_cnt <= '0;
            rr_ptr  <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
          end
        end
        MULT: begin
          acc     <= acc_next;
          bit_cnt <= bit_cnt + CW'(1);
          if (last_bit) begin
            res_data_q  <= sat_value;
            res_id_q    <= cur_id;
            res_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_data  = res_data_q;

  // Sticky deadline-miss flag; a new miss takes priority over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (sample_tick && (busy || (|bus.req_valid))) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_scheduler.sv
// Self-checking bench for mult_scheduler: table of known products, randomized
// products against a plain-arithmetic Q1.15 model, and hand-written sequences
// for latency, round-robin order, operand capture, overrun and mid-op reset.
module tb_mult_scheduler;
  localparam int WIDTH = 16;
  localparam int NREQ  = 3;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_tick = 1'b0;
  logic overrun_clr = 1'b0;
  logic busy;
  logic overrun;

  int vectors = 0;
  int miscompares = 0;

  mult_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  mult_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .overrun_clr (overrun_clr),
    .bus         (bus.slave),
    .busy        (busy),
    .overrun     (overrun)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[10];

  int          rr_id[9];
  int          rr_cyc[9];
  logic [15:0] rr_data[9];

  // Q1.15 product from the arithmetic definition: exact signed product,
  // magnitude rounded half up at bit 15, sign restored, then clamped.
  function automatic logic [15:0] ref_mult(input logic [15:0] a, input logic [15:0] b);
    longint p, mag, r;
    logic [63:0] rv;
    p   = longint'($signed(a)) * longint'($signed(b));
    mag = (p < 0) ? -p : p;
    r   = (mag + 16384) / 32768;
    if (p < 0) r = -r;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    rv = r;
    return rv[15:0];
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation from a single requester, entered while idle. Returns the
  // result and the cycle offset of res_valid relative to the handshake cycle.
  // With corrupt set, the operands are overwritten right after the handshake.
  task automatic apply_stimulus(input int id, input logic [15:0] a, input logic [15:0] b,
                                input bit corrupt, output logic [15:0] data,
                                output logic [IDW-1:0] rid, output int lat);
    logic [NREQ-1:0] exp_ready;
    bus.req_valid = '0;
    bus.req_valid[id] = 1'b1;
    bus.req_a[id*WIDTH +: WIDTH] = a;
    bus.req_b[id*WIDTH +: WIDTH] = b;
    exp_ready = '0;
    exp_ready[id] = 1'b1;
    lat = -1;
    data = '0;
    rid = '0;
    #1;
    check_output("grant", 32'(bus.req_ready), 32'(exp_ready));
    step();
    bus.req_valid = '0;
    if (corrupt) begin
      bus.req_a[id*WIDTH +: WIDTH] = 16'h7FFF;
      bus.req_b[id*WIDTH +: WIDTH] = 16'h8000;
    end
    for (int n = 1; n <= 40; n++) begin
      if (bus.res_valid) begin
        lat = n;
        data = bus.res_data;
        rid = bus.res_id;
        break;
      end
      step();
    end
    if (lat < 0) check_output("result_timeout", 32'(lat), 32'd17);
    step();
  endtask

  initial begin
    logic [15:0]    d;
    logic [IDW-1:0] rid;
    int             lat;
    int             busy_cnt;
    int             rv_cycle;
    int             onehot_err;
    int             nres;
    int             rv_cnt;
    int             id;
    logic [15:0]    ra, rb;
    logic [NREQ*WIDTH-1:0] pa, pb;

    tbl[0] = '{"q_half_sq",  16'h4000, 16'h4000, 16'h2000};
    tbl[1] = '{"neg1_sq",    16'h8000, 16'h8000, 16'h7FFF};
    tbl[2] = '{"neg1_max",   16'h8000, 16'h7FFF, 16'h8001};
    tbl[3] = '{"neg1_half",  16'h8000, 16'h4000, 16'hC000};
    tbl[4] = '{"zero_neg",   16'h0000, 16'h8000, 16'h0000};
    tbl[5] = '{"round_up",   16'h0001, 16'h4000, 16'h0001};
    tbl[6] = '{"max_sq",     16'h7FFF, 16'h7FFF, 16'h7FFE};
    tbl[7] = '{"m1_m1",      16'hFFFF, 16'hFFFF, 16'h0000};
    tbl[8] = '{"negq_half",  16'hC000, 16'h4000, 16'hE000};
    tbl[9] = '{"round_neg",  16'h0001, 16'hC000, 16'hFFFF};

    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;

    // Reset values
    #12;
    check_output("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_output("rst_res_id", 32'(bus.res_id), 32'd0);
    check_output("rst_res_data", 32'(bus.res_data), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_overrun", 32'(overrun), 32'd0);
    check_output("rst_ready", 32'(bus.req_ready), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single request: latency and busy window
    bus.req_valid = 3'b001;
    bus.req_a[15:0] = 16'h4000;
    bus.req_b[15:0] = 16'h4000;
    #1;
    check_output("single_grant", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = '0;
    busy_cnt = 0;
    rv_cycle = -1;
    d = '0;
    rid = '1;
    for (int n = 1; n <= 17; n++) begin
      if (busy) busy_cnt++;
      if (bus.res_valid && rv_cycle < 0) begin
        rv_cycle = n;
        d = bus.res_data;
        rid = bus.res_id;
      end
      step();
    end
    check_output("single_busy_cycles", 32'(busy_cnt), 32'd17);
    check_output("single_latency", 32'(rv_cycle), 32'd17);
    check_output("single_data", 32'(d), 32'h2000);
    check_output("single_id", 32'(rid), 32'd0);
    check_output("single_busy_after", 32'(busy), 32'd0);
    check_output("single_valid_pulse", 32'(bus.res_valid), 32'd0);
    check_output("single_data_hold", 32'(bus.res_data), 32'h2000);

    // Table of known products, rotating through requesters
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(i % NREQ, tbl[i].a, tbl[i].b, 1'b0, d, rid, lat);
      check_output(tbl[i].name, 32'(d), 32'(tbl[i].exp));
      check_output({tbl[i].name, "_id"}, 32'(rid), 32'(i % NREQ));
      check_output({tbl[i].name, "_lat"}, 32'(lat), 32'd17);
    end

    // Operand capture: inputs changed right after the handshake are ignored
    apply_stimulus(2, 16'h2000, 16'h4000, 1'b1, d, rid, lat);
    check_output("capture_data", 32'(d), 32'h1000);
    check_output("capture_id", 32'(rid), 32'd2);

    // Round-robin with all requesters held valid from a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    pa = {16'h6000, 16'h5000, 16'h4000};
    pb = {16'h9000, 16'h2000, 16'h7000};
    bus.req_a = pa;
    bus.req_b = pb;
    bus.req_valid = 3'b111;
    #1;
    onehot_err = 0;
    nres = 0;
    for (int c = 0; c < 250 && nres < 9; c++) begin
      if ($countones(bus.req_ready) > 1) onehot_err++;
      if (bus.res_valid) begin
        rr_id[nres] = int'(bus.res_id);
        rr_cyc[nres] = c;
        rr_data[nres] = bus.res_data;
        nres++;
        if (nres == 9) bus.req_valid = '0;
      end
      step();
    end
    check_output("rr_count", 32'(nres), 32'd9);
    check_output("rr_onehot", 32'(onehot_err), 32'd0);
    for (int k = 0; k < nres; k++) begin
      check_output("rr_order", 32'(rr_id[k]), 32'(k % NREQ));
      check_output("rr_data", 32'(rr_data[k]),
                   32'(ref_mult(pa[(k % NREQ)*WIDTH +: WIDTH], pb[(k % NREQ)*WIDTH +: WIDTH])));
      if (k > 0) check_output("rr_spacing", 32'(rr_cyc[k] - rr_cyc[k-1]), 32'd18);
    end
    step();

    // Randomized products against the reference model
    for (int i = 0; i < 24; i++) begin
      id = $urandom_range(0, NREQ - 1);
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 8 == 0) ra = 16'h8000;
      if (i % 8 == 1) rb = 16'h0000;
      apply_stimulus(id, ra, rb, 1'b0, d, rid, lat);
      check_output("rand_data", 32'(d), 32'(ref_mult(ra, rb)));
      check_output("rand_id", 32'(rid), 32'(id));
    end

    // Overrun: tick during MULT sets, set beats a simultaneous clear
    check_output("ovr_start", 32'(overrun), 32'd0);
    bus.req_valid = 3'b100;
    bus.req_a[2*WIDTH +: WIDTH] = 16'h1234;
    bus.req_b[2*WIDTH +: WIDTH] = 16'h4321;
    #1;
    step();
    bus.req_valid = '0;
    repeat (3) step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check_output("ovr_set", 32'(overrun), 32'd1);
    repeat (3) step();
    check_output("ovr_sticky", 32'(overrun), 32'd1);
    sample_tick = 1'b1;
    overrun_clr = 1'b1;
    step();
    sample_tick = 1'b0;
    overrun_clr = 1'b0;
    check_output("ovr_set_wins", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check_output("ovr_clear", 32'(overrun), 32'd0);
    for (int n = 0; n < 40 && busy; n++) step();
    check_output("ovr_drain", 32'(busy), 32'd0);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check_output("ovr_idle_tick", 32'(overrun), 32'd0);

    // Reset in the middle of an operation
    bus.req_valid = 3'b010;
    bus.req_a[1*WIDTH +: WIDTH] = 16'h4000;
    bus.req_b[1*WIDTH +: WIDTH] = 16'h4000;
    #1;
    step();
    bus.req_valid = '0;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    check_output("midrst_valid", 32'(bus.res_valid), 32'd0);
    check_output("midrst_id", 32'(bus.res_id), 32'd0);
    check_output("midrst_data", 32'(bus.res_data), 32'd0);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_overrun", 32'(overrun), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    rv_cnt = 0;
    for (int n = 0; n < 25; n++) begin
      if (bus.res_valid) rv_cnt++;
      step();
    end
    check_output("midrst_no_result", 32'(rv_cnt), 32'd0);
    pa = {16'h2000, 16'h7000, 16'hA000};
    pb = {16'h3000, 16'h1111, 16'h5555};
    bus.req_a = pa;
    bus.req_b = pb;
    bus.req_valid = 3'b111;
    #1;
    check_output("midrst_first_grant", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = '0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (bus.res_valid) begin
        lat = n;
        d = bus.res_data;
        rid = bus.res_id;
        break;
      end
      step();
    end
    check_output("midrst_lat", 32'(lat), 32'd17);
    check_output("midrst_res_id", 32'(rid), 32'd0);
    check_output("midrst_res_data", 32'(d), 32'(ref_mult(16'hA000, 16'h5555)));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so a stuck design cannot hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
